// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the add/sub accumulator sequencer.
package addsub_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_XSUB = 2'b01,
      OP_ASUB = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      ISSUE,
      GAP,
      DRAIN,
      DONE
   } state_e;

   localparam int CLR_CYCLES = 2;

   // Returns {sel_1_2, sel_3}; the reserved op folds onto ADD.
   function automatic logic [1:0] op_to_sel(input op_e op);
      logic [1:0] sel;
      case (op)
         OP_XSUB: sel = 2'b10;
         OP_ASUB: sel = 2'b00;
         default: sel = 2'b11;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/addsub_acc_seq.sv
// Job sequencer for the 16-bit add/sub accumulator datapath.
// Optional intermediate-result port enabled by ADDSUB_SEQ_MID_EN.
module addsub_acc_seq
   import addsub_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_start,
   input  logic [LEN_W-1:0] job_len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   output logic [WIDTH-1:0] dp_in,
   output logic             dp_rst_na,
   output logic             dp_sel_1_2,
   output logic             dp_sel_3,
   input  logic [WIDTH-1:0] dp_out,
`ifdef ADDSUB_SEQ_MID_EN
   output logic             mid_valid,
   output logic [WIDTH-1:0] mid_data,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             op_err
);

   localparam logic [1:0] CLR_LAST = 2'(CLR_CYCLES - 1);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [1:0]       clr_q, clr_d;
   logic             rst_na_q, rst_na_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             err_q, err_d;
   logic             hs;

   assign in_ready = (state_q == ISSUE) && !rst;
   assign hs       = in_ready && in_valid;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (job_start) begin
               len_d   = job_len;
               cnt_d   = '0;
               clr_d   = '0;
               err_d   = 1'b0;
               state_d = CLR;
            end
         end
         CLR: begin
            clr_d = clr_q + 2'd1;
            // N=0 still drains so its result lands at the usual offset.
            if (clr_q == CLR_LAST)
               state_d = (len_q != '0) ? ISSUE : DRAIN;
         end
         ISSUE: begin
            if (hs) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (op_e'(in_op) == OP_RSVD)
                  err_d = 1'b1;
            end
            state_d = GAP;
         end
         GAP: begin
            state_d = (cnt_q < len_q) ? ISSUE : DRAIN;
         end
         DRAIN: begin
            res_d   = dp_out;
            state_d = DONE;
         end
         DONE: begin
            if (res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rst_na_d = (state_d != CLR);
      sel_d    = op_to_sel(hs ? op_e'(in_op) : OP_ADD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         clr_q    <= '0;
         rst_na_q <= 1'b0;
         sel_q    <= 2'b11;
         res_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         clr_q    <= clr_d;
         rst_na_q <= rst_na_d;
         sel_q    <= sel_d;
         res_q    <= res_d;
         err_q    <= err_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign dp_in      = hs ? in_data : '0;
   assign dp_rst_na  = rst_na_q;
   assign dp_sel_1_2 = sel_q[1];
   assign dp_sel_3   = sel_q[0];
   assign res_valid  = (state_q == DONE);
   assign res_data   = res_q;
   assign op_err     = err_q;

`ifdef ADDSUB_SEQ_MID_EN
   logic [1:0] hs_q, hs_d;

   assign hs_d = {hs_q[0], hs};

   always_ff @(posedge clk) begin
      if (rst) hs_q <= '0;
      else     hs_q <= hs_d;
   end

   assign mid_valid = hs_q[1];
   assign mid_data  = dp_out;
`endif

endmodule

// File: tb/tb_addsub_acc_seq.sv
// Directed bench: sequencer driving a behavioural accumulator datapath.
module tb_addsub_acc_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_start = 1'b0;
   logic [7:0]  job_len = '0;
   logic        busy;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  in_op = '0;
   logic [15:0] dp_in;
   logic        dp_rst_na;
   logic        dp_sel_1_2;
   logic        dp_sel_3;
   logic [15:0] dp_out;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        op_err;
`ifdef ADDSUB_SEQ_MID_EN
   logic        mid_valid;
   logic [15:0] mid_data;
   logic [15:0] exp_mid [$];
`endif

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [15:0] dat [0:3];
   logic [1:0]  ops [0:3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_acc_seq #(.WIDTH(16), .LEN_W(8)) dut (
      .clk(clk), .rst(rst),
      .job_start(job_start), .job_len(job_len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_op(in_op),
      .dp_in(dp_in), .dp_rst_na(dp_rst_na),
      .dp_sel_1_2(dp_sel_1_2), .dp_sel_3(dp_sel_3),
      .dp_out(dp_out),
`ifdef ADDSUB_SEQ_MID_EN
      .mid_valid(mid_valid), .mid_data(mid_data),
`endif
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .op_err(op_err)
   );

   logic [15:0] opnd_r, fb_r, out_r;
   always_ff @(posedge clk or negedge dp_rst_na) begin
      if (!dp_rst_na) begin
         opnd_r <= '0;
         fb_r   <= '0;
         out_r  <= '0;
      end else begin
         opnd_r <= dp_in;
         fb_r   <= out_r;
         case ({dp_sel_1_2, dp_sel_3})
            2'b10:   out_r <= opnd_r - fb_r;
            2'b00:   out_r <= fb_r - opnd_r;
            default: out_r <= opnd_r + fb_r;
         endcase
      end
   end
   assign dp_out = out_r;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef ADDSUB_SEQ_MID_EN
   always @(negedge clk) begin
      if (mid_valid === 1'b1) begin
         if (exp_mid.size() == 0) chk("mid_extra", 32'(mid_data), 32'hdead);
         else chk("mid_data", 32'(mid_data), 32'(exp_mid.pop_front()));
      end
   end
`endif

   task automatic run_job(input string tag, input int n, input int stall,
                          input int exp_lat, input logic [15:0] exp_res,
                          input logic exp_err);
      int idx, slot, c0, lat;
      bit done;
      idx = 0; slot = 0; lat = -1; done = 0;
      @(posedge clk); #1;
      job_start = 1'b1; job_len = 8'(n); c0 = cyc;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clk); #1;
         job_start = 1'b0; in_valid = 1'b0;
         if (in_ready) begin
            if (slot != stall && idx < n) begin
               in_valid = 1'b1; in_data = dat[idx]; in_op = ops[idx];
            end
            slot++;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         if (res_valid) begin done = 1; lat = cyc - c0; end
      end
      in_valid = 1'b0;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, 32'(res_data), 32'(exp_res));
      chk({tag, "_err"}, 32'(op_err), 32'(exp_err));
`ifdef ADDSUB_SEQ_MID_EN
      chk({tag, "_midleft"}, exp_mid.size(), 0);
`endif
   endtask

   task automatic release_res(input string tag);
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_rvhold"}, 32'(res_valid), 1);
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_rvlow"}, 32'(res_valid), 0);
      chk({tag, "_idle"}, 32'(busy), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_rdy"}, 32'(in_ready), 0);
      chk({tag, "_dpin"}, 32'(dp_in), 0);
      chk({tag, "_rstna"}, 32'(dp_rst_na), 0);
      chk({tag, "_s12"}, 32'(dp_sel_1_2), 1);
      chk({tag, "_s3"}, 32'(dp_sel_3), 1);
      chk({tag, "_rv"}, 32'(res_valid), 0);
      chk({tag, "_rd"}, 32'(res_data), 0);
      chk({tag, "_err"}, 32'(op_err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int h;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("rst0");
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst0_rel", 32'(dp_rst_na), 1);

      dat[0] = 5; dat[1] = 7; dat[2] = 2;
      ops[0] = 2'b00; ops[1] = 2'b00; ops[2] = 2'b00;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'd5, 16'd12, 16'd14};
`endif
      run_job("t1", 3, -1, 10, 16'd14, 1'b0);
      release_res("t1");

      dat[0] = 10; dat[1] = 3; dat[2] = 20;
      ops[0] = 2'b00; ops[1] = 2'b10; ops[2] = 2'b01;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'd10, 16'd7, 16'd13};
`endif
      run_job("t2", 3, -1, 10, 16'd13, 1'b0);
      release_res("t2");

      dat[0] = 5; dat[1] = 7; dat[2] = 2;
      ops[0] = 2'b00; ops[1] = 2'b00; ops[2] = 2'b00;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'd5, 16'd12, 16'd14};
`endif
      run_job("t3", 3, 1, 12, 16'd14, 1'b0);
      release_res("t3");

      dat[0] = 16'hFFFF; dat[1] = 2;
      ops[0] = 2'b00; ops[1] = 2'b00;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'hFFFF, 16'h0001};
`endif
      res_ready = 1'b1;
      run_job("t4", 2, -1, 8, 16'h0001, 1'b0);
      @(negedge clk);
      chk("t4_samecyc_rv", 32'(res_valid), 0);
      chk("t4_samecyc_busy", 32'(busy), 0);
      res_ready = 1'b0;

      dat[0] = 0; ops[0] = 2'b10;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'h0000};
`endif
      run_job("t5", 1, -1, 6, 16'h0000, 1'b0);
      release_res("t5");

      dat[0] = 3; dat[1] = 4;
      ops[0] = 2'b00; ops[1] = 2'b11;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'd3, 16'd7};
`endif
      run_job("t6", 2, -1, 8, 16'd7, 1'b1);
      release_res("t6");

      run_job("t7", 0, -1, 4, 16'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 job_start = (i == 2);
         job_len = 8'd3;
         @(negedge clk);
         chk("t7_hold_rv", 32'(res_valid), 1);
         chk("t7_hold_rd", 32'(res_data), 0);
      end
      @(posedge clk); #1 job_start = 1'b0;
      @(negedge clk);
      chk("t7_still_done", 32'(res_valid), 1);
      release_res("t7");

      dat[0] = 1; dat[1] = 2; dat[2] = 3; dat[3] = 4;
      ops[0] = 2'b00; ops[1] = 2'b00; ops[2] = 2'b11; ops[3] = 2'b00;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'd1, 16'd3, 16'd6};
`endif
      @(posedge clk); #1 job_start = 1'b1; job_len = 8'd4;
      h = 0;
      for (int k = 0; k < 40 && h < 3; k++) begin
         @(posedge clk); #1;
         job_start = 1'b0;
         in_valid = in_ready; in_data = dat[h]; in_op = ops[h];
         @(negedge clk);
         if (in_valid && in_ready) h++;
      end
      chk("ab_hs", h, 3);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("ab_err_pre", 32'(op_err), 1);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1; in_data = dat[3]; in_op = ops[3];
      @(negedge clk);
      chk("ab_busy_pre", 32'(busy), 1);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk_reset("ab");
      @(posedge clk); #1;
      @(negedge clk);
      chk("ab_rel", 32'(dp_rst_na), 1);
      chk("ab_norv", 32'(res_valid), 0);

      dat[0] = 9; ops[0] = 2'b01;
`ifdef ADDSUB_SEQ_MID_EN
      exp_mid = '{16'd9};
`endif
      run_job("t8", 1, -1, 6, 16'd9, 1'b0);
      release_res("t8");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
